// File: rtl/riscv_pkg.sv
// Shared constants for the RV32M divide unit: op codes, FSM encoding, default width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3[1:0] of DIV/DIVU/REM/REMU
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sub_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it did not borrow.
module div_sub_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quo_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The shifted remainder keeps its carry-out bit so divisors above 2^(XLEN-1) stay exact.
  assign shifted   = {rem_i, bit_i};
  assign trial     = shifted - {1'b0, divisor_i};
  assign quo_bit_o = ~trial[XLEN];
  assign rem_o     = quo_bit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/riscv_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock,
// with start/done handshake, flush abort and single-cycle special-case bypass.
module riscv_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  div_state_e      state_q, state_d;
  logic            sel_rem_q, sel_rem_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            special_q, special_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] step_rem;
  logic            step_bit;
  logic            is_signed;

  div_sub_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[XLEN-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_bit_o (step_bit)
  );

  assign is_signed = ~op[0];

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: if (start) begin
          sel_rem_d = op[1];
          neg_a_d   = is_signed & dividend[XLEN-1];
          neg_b_d   = is_signed & divisor[XLEN-1];
          quo_d     = neg_a_d ? -dividend : dividend;
          dvs_d     = neg_b_d ? -divisor : divisor;
          rem_d     = '0;
          cnt_d     = CNT_W'(XLEN);
          special_d = 1'b0;
          state_d   = DIV_CALC;
          // Special results are parked in quo_q and passed through FIX untouched.
          if (divisor == '0) begin
            special_d = 1'b1;
            quo_d     = op[1] ? dividend : '1;
            state_d   = DIV_FIX;
          end else if (is_signed && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1) begin
            special_d = 1'b1;
            quo_d     = op[1] ? '0 : dividend;
            state_d   = DIV_FIX;
          end
        end
        DIV_CALC: begin
          rem_d = step_rem;
          quo_d = {quo_q[XLEN-2:0], step_bit};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DIV_FIX;
        end
        DIV_FIX: begin
          if (special_q)      result_d = quo_q;
          else if (sel_rem_q) result_d = neg_a_q ? -rem_q : rem_q;
          else                result_d = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
          state_d = DIV_DONE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      sel_rem_q <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign done   = (state_q == DIV_DONE);
  assign result = result_q;

endmodule
